// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Three-port register-file write-back arbiter. Each requester presents a
//   destination register number and write data. One requester is accepted per
//   cycle (combinational grant). The accepted write appears one cycle later
//   as a one-hot register-file write enable plus the data.
//
//   Selection is round-robin by default. Defining WBA_FIXED_PRIO_EN switches
//   it to fixed priority Req0 > Req1 > Req2. Last is still tracked in that mode.
//
// Ports
//   Clk            : clock, rising edge
//   Clrn           : asynchronous active-low reset
//   Req0..Req2     : requester has a register write pending
//   Rd0..Rd2 [4:0] : destination register of each requester
//   D0..D2  [31:0] : write data of each requester
//   Hold           : register file cannot accept a write this cycle
//   Gnt0..Gnt2     : combinational, one-hot or zero, requester accepted now
//   Wen     [31:0] : registered one-hot write enable (r0 never enabled)
//   Wd      [31:0] : registered write data
//   Last    [1:0]  : registered index of the last granted requester
// ---------------------------------------------------------------------------
module wb_port_arbiter (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        Req2,
  input  logic [4:0]  Rd0,
  input  logic [4:0]  Rd1,
  input  logic [4:0]  Rd2,
  input  logic [31:0] D0,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        Hold,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        Gnt2,
  output logic [31:0] Wen,
  output logic [31:0] Wd,
  output logic [1:0]  Last
);

  // 5-to-32 one-hot decode; register 0 is hard-wired and never enabled.
  function automatic logic [31:0] decode_rd(input logic [4:0] rd);
    logic [31:0] onehot;
    onehot = 32'd0;
    if (rd != 5'd0) begin
      onehot[rd] = 1'b1;
    end else begin
      onehot = 32'd0;
    end
    return onehot;
  endfunction

  // Round-robin pick: returns {valid, index}; the search starts after 'last'.
  // An out-of-range last (3) behaves like 2, so requester 0 is searched first.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [2:0] pick;
    pick = 3'b000;
    case (last)
      2'd0: begin
        if (req[1])      pick = 3'b101;
        else if (req[2]) pick = 3'b110;
        else if (req[0]) pick = 3'b100;
        else             pick = 3'b000;
      end
      2'd1: begin
        if (req[2])      pick = 3'b110;
        else if (req[0]) pick = 3'b100;
        else if (req[1]) pick = 3'b101;
        else             pick = 3'b000;
      end
      default: begin
        if (req[0])      pick = 3'b100;
        else if (req[1]) pick = 3'b101;
        else if (req[2]) pick = 3'b110;
        else             pick = 3'b000;
      end
    endcase
    return pick;
  endfunction

  logic [31:0] wen_q, wen_d;
  logic [31:0] wd_q, wd_d;
  logic [1:0]  last_q, last_d;

  logic [2:0]  req_v;
  logic [2:0]  pick;
  logic        gnt_any;
  logic [1:0]  gnt_idx;
  logic [2:0]  gnt;
  logic [4:0]  sel_rd;
  logic [31:0] sel_d;

  // Grant selection; Hold and an active reset both suppress every grant.
  always_comb begin
    req_v = {Req2, Req1, Req0} & {3{~Hold & Clrn}};
    pick  = 3'b000;
`ifdef WBA_FIXED_PRIO_EN
    if (req_v[0])      pick = 3'b100;
    else if (req_v[1]) pick = 3'b101;
    else if (req_v[2]) pick = 3'b110;
    else               pick = 3'b000;
`else
    pick = rr_pick(req_v, last_q);
`endif
    gnt_any = pick[2];
    gnt_idx = pick[1:0];
    if (gnt_any) begin
      gnt = 3'b001 << gnt_idx;
    end else begin
      gnt = 3'b000;
    end
  end

  // Route the granted requester's register number and data.
  always_comb begin
    sel_rd = 5'd0;
    sel_d  = 32'd0;
    case (gnt_idx)
      2'd0: begin
        sel_rd = Rd0;
        sel_d  = D0;
      end
      2'd1: begin
        sel_rd = Rd1;
        sel_d  = D1;
      end
      default: begin
        sel_rd = Rd2;
        sel_d  = D2;
      end
    endcase
  end

  // Next-state for the write-back stage; a cycle without a grant clears it.
  always_comb begin
    wen_d  = 32'd0;
    wd_d   = 32'd0;
    last_d = last_q;
    if (gnt_any) begin
      wen_d  = decode_rd(sel_rd);
      wd_d   = sel_d;
      last_d = gnt_idx;
    end else begin
      wen_d  = 32'd0;
      wd_d   = 32'd0;
      last_d = last_q;
    end
  end

  // Write-back stage and arbitration history registers.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      wen_q  <= 32'd0;
      wd_q   <= 32'd0;
      last_q <= 2'd2;
    end else begin
      wen_q  <= wen_d;
      wd_q   <= wd_d;
      last_q <= last_d;
    end
  end

  assign Gnt0 = gnt[0];
  assign Gnt1 = gnt[1];
  assign Gnt2 = gnt[2];
  assign Wen  = wen_q;
  assign Wd   = wd_q;
  assign Last = last_q;

endmodule
